// File: rtl/tetris_pkg.sv
// Shared types and default constants for the falling-piece position controller.
// The optional hard-drop state is present only when PIECE_HARD_DROP_EN is defined.
package tetris_pkg;

  localparam int BOARD_W_DEF       = 10;
  localparam int BOARD_H_DEF       = 20;
  localparam int SPAWN_X_DEF       = 4;
  localparam int GRAVITY_TICKS_DEF = 8;

  typedef logic [1:0] rot_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN_CHK,
    ST_FALL,
    ST_WAIT,
    ST_LOCK,
    ST_OVER
`ifdef PIECE_HARD_DROP_EN
    , ST_DROP
`endif
  } state_e;

  typedef enum logic [1:0] {
    MV_ROT,
    MV_LEFT,
    MV_RIGHT,
    MV_DOWN
  } move_e;

  // Clockwise quarter turn; the 2-bit type wraps 3 -> 0 naturally.
  function automatic rot_t rot_next(input rot_t r);
    return r + 2'd1;
  endfunction

endpackage

// File: rtl/piece_pos_ctrl_gravity_timer.sv
// Gravity timer: counts 0..TICKS-1 while enabled, pulses expire_o on the
// last count and wraps. A clear forces the count back to zero and wins over
// the enable.
module gravity_timer #(
  parameter  int TICKS = 8,
  localparam int CW    = (TICKS > 1) ? $clog2(TICKS) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CW-1:0] count_q;
  logic          at_end;

  assign at_end   = (count_q == CW'(TICKS - 1));
  assign expire_o = en_i && at_end;

  // Tick counter with clear priority and wrap on expiry.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= at_end ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/piece_pos_ctrl.sv
// Active-piece position controller: tracks x, y and rotation, validates every
// candidate move with the board through a query/response handshake, applies
// gravity, detects landing and flags game-over on a colliding spawn.
// Optional feature macro: PIECE_HARD_DROP_EN adds the hard_drop input and a
// DROP loop that walks the piece down one query at a time until it lands.
module piece_pos_ctrl
  import tetris_pkg::*;
#(
  parameter  int BOARD_W       = BOARD_W_DEF,
  parameter  int BOARD_H       = BOARD_H_DEF,
  parameter  int SPAWN_X       = SPAWN_X_DEF,
  parameter  int GRAVITY_TICKS = GRAVITY_TICKS_DEF,
  localparam int X_W           = $clog2(BOARD_W),
  localparam int Y_W           = $clog2(BOARD_H)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           spawn,
  input  logic           left,
  input  logic           right,
  input  logic           drop,
  input  logic           rotate,
`ifdef PIECE_HARD_DROP_EN
  input  logic           hard_drop,
`endif
  output logic           q_valid,
  output logic [X_W-1:0] q_x,
  output logic [Y_W-1:0] q_y,
  output logic [1:0]     q_rot,
  input  logic           q_resp_valid,
  input  logic           q_hit,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     rot,
  output logic           active,
  output logic           lock_pulse,
  output logic           game_over
);

  localparam logic [X_W-1:0] X_SPAWN = X_W'(SPAWN_X);
  localparam logic [X_W-1:0] X_MAX   = X_W'(BOARD_W - 1);
  localparam logic [Y_W-1:0] Y_MAX   = Y_W'(BOARD_H - 1);

  state_e         state_q;
  move_e          mv_q;
  logic           q_valid_q;
  logic [X_W-1:0] q_x_q;
  logic [Y_W-1:0] q_y_q;
  rot_t           q_rot_q;
  logic [X_W-1:0] pos_x_q;
  logic [Y_W-1:0] pos_y_q;
  rot_t           rot_q;
  logic           active_q;
  logic           lock_pulse_q;
  logic           game_over_q;
  logic           grav_pend_q;

  logic grav_en;
  logic grav_clr;
  logic grav_expire;
  logic down_commit;

  // Move chosen in FALL for this cycle.
  logic           fall_go;
  logic           fall_land;
  logic           fall_down;
  move_e          fall_mv_d;
  logic [X_W-1:0] fall_x_d;
  logic [Y_W-1:0] fall_y_d;
  rot_t           fall_rot_d;

  assign grav_en     = (state_q == ST_FALL) || (state_q == ST_WAIT);
  assign down_commit = (state_q == ST_WAIT) && q_resp_valid && !q_hit && (mv_q == MV_DOWN);
  assign grav_clr    = down_commit ||
                       ((state_q == ST_SPAWN_CHK) && q_resp_valid && !q_hit);

  gravity_timer #(
    .TICKS (GRAVITY_TICKS)
  ) u_gravity_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (grav_clr),
    .en_i     (grav_en),
    .expire_o (grav_expire)
  );

  // Pick the single FALL move by priority rotate > left > right > down.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    fall_go    = 1'b0;
    fall_land  = 1'b0;
    fall_down  = 1'b0;
    fall_mv_d  = MV_DOWN;
    fall_x_d   = pos_x_q;
    fall_y_d   = pos_y_q;
    fall_rot_d = rot_q;
    if (rotate) begin
      fall_go    = 1'b1;
      fall_mv_d  = MV_ROT;
      fall_rot_d = rot_next(rot_q);
    end else if (left && !right) begin
      // A left at the wall is consumed without a query.
      if (pos_x_q != '0) begin
        fall_go   = 1'b1;
        fall_mv_d = MV_LEFT;
        fall_x_d  = pos_x_q - X_W'(1);
      end
    end else if (right && !left) begin
      if (pos_x_q != X_MAX) begin
        fall_go   = 1'b1;
        fall_mv_d = MV_RIGHT;
        fall_x_d  = pos_x_q + X_W'(1);
      end
    end else if (drop || grav_pend_q || grav_expire) begin
      // Left+right cancel and fall through to here; a pending gravity step
      // and a drop are the same down request.
      fall_down = 1'b1;
      if (pos_y_q == Y_MAX) begin
        fall_land = 1'b1;
      end else begin
        fall_go  = 1'b1;
        fall_y_d = pos_y_q + Y_W'(1);
      end
    end
  end

  // Main controller FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mv_q         <= MV_DOWN;
      q_valid_q    <= 1'b0;
      q_x_q        <= X_SPAWN;
      q_y_q        <= '0;
      q_rot_q      <= '0;
      pos_x_q      <= X_SPAWN;
      pos_y_q      <= '0;
      rot_q        <= '0;
      active_q     <= 1'b0;
      lock_pulse_q <= 1'b0;
      game_over_q  <= 1'b0;
      grav_pend_q  <= 1'b0;
    end else begin
      lock_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          grav_pend_q <= 1'b0;
          if (spawn) begin
            state_q   <= ST_SPAWN_CHK;
            pos_x_q   <= X_SPAWN;
            pos_y_q   <= '0;
            rot_q     <= '0;
            q_valid_q <= 1'b1;
            q_x_q     <= X_SPAWN;
            q_y_q     <= '0;
            q_rot_q   <= '0;
          end
        end

        ST_SPAWN_CHK: begin
          if (q_resp_valid) begin
            q_valid_q <= 1'b0;
            if (q_hit) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q     <= ST_FALL;
              active_q    <= 1'b1;
              grav_pend_q <= 1'b0;
            end
          end
        end

        ST_FALL: begin
          // An expiry not consumed as this cycle's down move is remembered.
          grav_pend_q <= fall_down ? 1'b0 : (grav_pend_q | grav_expire);
`ifdef PIECE_HARD_DROP_EN
          if (hard_drop) begin
            if (pos_y_q == Y_MAX) begin
              state_q      <= ST_LOCK;
              lock_pulse_q <= 1'b1;
              active_q     <= 1'b0;
            end else begin
              state_q   <= ST_DROP;
              mv_q      <= MV_DOWN;
              q_valid_q <= 1'b1;
              q_x_q     <= pos_x_q;
              q_y_q     <= pos_y_q + Y_W'(1);
              q_rot_q   <= rot_q;
            end
          end else
`endif
          if (fall_land) begin
            state_q      <= ST_LOCK;
            lock_pulse_q <= 1'b1;
            active_q     <= 1'b0;
          end else if (fall_go) begin
            state_q   <= ST_WAIT;
            mv_q      <= fall_mv_d;
            q_valid_q <= 1'b1;
            q_x_q     <= fall_x_d;
            q_y_q     <= fall_y_d;
            q_rot_q   <= fall_rot_d;
          end
        end

        ST_WAIT: begin
          grav_pend_q <= grav_pend_q | (grav_expire & ~down_commit);
          if (q_resp_valid) begin
            q_valid_q <= 1'b0;
            if (!q_hit) begin
              state_q <= ST_FALL;
              pos_x_q <= q_x_q;
              pos_y_q <= q_y_q;
              rot_q   <= q_rot_q;
            end else if (mv_q == MV_DOWN) begin
              state_q      <= ST_LOCK;
              lock_pulse_q <= 1'b1;
              active_q     <= 1'b0;
            end else begin
              state_q <= ST_FALL;
            end
          end
        end

`ifdef PIECE_HARD_DROP_EN
        ST_DROP: begin
          if (q_resp_valid) begin
            if (q_hit) begin
              state_q      <= ST_LOCK;
              lock_pulse_q <= 1'b1;
              active_q     <= 1'b0;
              q_valid_q    <= 1'b0;
            end else begin
              pos_y_q <= q_y_q;
              if (q_y_q == Y_MAX) begin
                state_q      <= ST_LOCK;
                lock_pulse_q <= 1'b1;
                active_q     <= 1'b0;
                q_valid_q    <= 1'b0;
              end else begin
                q_y_q <= q_y_q + Y_W'(1);
              end
            end
          end
        end
`endif

        ST_LOCK: begin
          state_q     <= ST_IDLE;
          grav_pend_q <= 1'b0;
        end

        ST_OVER: begin
          q_valid_q <= 1'b0;
          active_q  <= 1'b0;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign q_valid    = q_valid_q;
  assign q_x        = q_x_q;
  assign q_y        = q_y_q;
  assign q_rot      = q_rot_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign rot        = rot_q;
  assign active     = active_q;
  assign lock_pulse = lock_pulse_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_piece_pos_ctrl.sv
// Self-checking bench for piece_pos_ctrl: a behavioural piece model compared
// against the DUT every cycle, directed scenarios with literal expectations,
// then randomized commands and board responses.
module tb_piece_pos_ctrl;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int SX = 4;
  localparam int GT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spawn = 1'b0, left = 1'b0, right = 1'b0, drop = 1'b0, rotate = 1'b0;
  logic       q_resp_valid = 1'b0, q_hit = 1'b0;
  logic       q_valid;
  logic [3:0] q_x;
  logic [4:0] q_y;
  logic [1:0] q_rot;
  logic [3:0] pos_x;
  logic [4:0] pos_y;
  logic [1:0] rot;
  logic       active, lock_pulse, game_over;
`ifdef PIECE_HARD_DROP_EN
  logic       hard_drop = 1'b0;
`endif

  piece_pos_ctrl #(
    .BOARD_W       (W),
    .BOARD_H       (H),
    .SPAWN_X       (SX),
    .GRAVITY_TICKS (GT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spawn        (spawn),
    .left         (left),
    .right        (right),
    .drop         (drop),
    .rotate       (rotate),
`ifdef PIECE_HARD_DROP_EN
    .hard_drop    (hard_drop),
`endif
    .q_valid      (q_valid),
    .q_x          (q_x),
    .q_y          (q_y),
    .q_rot        (q_rot),
    .q_resp_valid (q_resp_valid),
    .q_hit        (q_hit),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .rot          (rot),
    .active       (active),
    .lock_pulse   (lock_pulse),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_SPAWNQ = 1, PH_FALL = 2, PH_QUERY = 3, PH_LAND = 4, PH_DEAD = 5;
  localparam int K_ROT = 0, K_SIDE = 1, K_DOWN = 2;

  int m_ph, m_x, m_y, m_r, m_cx, m_cy, m_cr, m_kind, m_grav;
  bit m_qv, m_active, m_lock, m_over, m_pend;

  task automatic model_reset();
    m_ph = PH_IDLE; m_x = SX; m_y = 0; m_r = 0;
    m_cx = SX; m_cy = 0; m_cr = 0; m_kind = K_DOWN; m_grav = 0;
    m_qv = 0; m_active = 0; m_lock = 0; m_over = 0; m_pend = 0;
  endtask

  task automatic launch(input int kind, input int x, input int y, input int r);
    m_kind = kind; m_cx = x; m_cy = y; m_cr = r; m_qv = 1; m_ph = PH_QUERY;
  endtask

  task automatic land();
    m_lock = 1; m_active = 0; m_qv = 0; m_ph = PH_LAND;
  endtask

  task automatic model_step();
    bit run, expire, dcommit;
    int ng, dh;
    run    = (m_ph == PH_FALL) || (m_ph == PH_QUERY);
    expire = run && (m_grav == GT - 1);
    ng     = run ? (m_grav + 1) % GT : m_grav;
    m_lock = 0;
    case (m_ph)
      PH_IDLE: begin
        m_pend = 0;
        if (spawn) begin
          m_x = SX; m_y = 0; m_r = 0;
          launch(K_DOWN, SX, 0, 0);
          m_ph = PH_SPAWNQ;
        end
      end
      PH_SPAWNQ: if (q_resp_valid) begin
        m_qv = 0;
        if (q_hit) begin m_over = 1; m_ph = PH_DEAD; end
        else begin m_active = 1; m_ph = PH_FALL; ng = 0; m_pend = 0; end
      end
      PH_FALL: begin
        dh = int'(right) - int'(left);
        if (rotate) begin
          launch(K_ROT, m_x, m_y, (m_r + 1) % 4);
          m_pend = m_pend | expire;
        end else if (dh != 0) begin
          if (m_x + dh >= 0 && m_x + dh <= W - 1) launch(K_SIDE, m_x + dh, m_y, m_r);
          m_pend = m_pend | expire;
        end else if (drop || m_pend || expire) begin
          m_pend = 0;
          if (m_y == H - 1) land();
          else launch(K_DOWN, m_x, m_y + 1, m_r);
        end
      end
      PH_QUERY: begin
        dcommit = q_resp_valid && !q_hit && (m_kind == K_DOWN);
        if (dcommit) ng = 0;
        m_pend = m_pend | (expire && !dcommit);
        if (q_resp_valid) begin
          m_qv = 0;
          if (!q_hit) begin m_x = m_cx; m_y = m_cy; m_r = m_cr; m_ph = PH_FALL; end
          else if (m_kind == K_DOWN) land();
          else m_ph = PH_FALL;
        end
      end
      PH_LAND: begin m_ph = PH_IDLE; m_pend = 0; end
      default: ;
    endcase
    m_grav = ng;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Single compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("q_valid", 32'(q_valid), 32'(m_qv));
      if (m_qv) begin
        check("q_x", 32'(q_x), m_cx);
        check("q_y", 32'(q_y), m_cy);
        check("q_rot", 32'(q_rot), m_cr);
      end
      check("pos_x", 32'(pos_x), m_x);
      check("pos_y", 32'(pos_y), m_y);
      check("rot", 32'(rot), m_r);
      check("active", 32'(active), 32'(m_active));
      check("lock_pulse", 32'(lock_pulse), 32'(m_lock));
      check("game_over", 32'(game_over), 32'(m_over));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_in();
    spawn = 0; left = 0; right = 0; drop = 0; rotate = 0; q_resp_valid = 0; q_hit = 0;
  endtask

  task automatic do_reset();
    clear_in();
    #1 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Spawn from IDLE with an immediate miss; returns at the first FALL cycle.
  task automatic spawn_ok();
    spawn = 1; tick(); spawn = 0;
    q_resp_valid = 1; q_hit = 0; tick(); q_resp_valid = 0;
  endtask

  // n down moves, each answered with a miss in the first WAIT cycle.
  task automatic drop_n(input int n);
    for (int i = 0; i < n; i++) begin
      drop = 1; tick(); drop = 0;
      q_resp_valid = 1; q_hit = 0; tick(); q_resp_valid = 0;
    end
  endtask

  // Walk to a wall, then push once more: the extra push must be rejected.
  task automatic wall_test(input bit go_left, input int n, input int exp_x);
    do_reset();
    spawn_ok();
    for (int i = 0; i < n; i++) begin
      left = go_left; right = !go_left; tick(); left = 0; right = 0;
      q_resp_valid = 1; q_hit = 0; tick(); q_resp_valid = 0;
    end
    left = go_left; right = !go_left; tick(); left = 0; right = 0;
    check(go_left ? "wall_left_noq" : "wall_right_noq", 32'(q_valid), 0);
    check(go_left ? "wall_left_x" : "wall_right_x", 32'(pos_x), exp_x);
  endtask

  int  dly;
  bit  in_q;

  initial begin
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset values.
    check("rst_pos_x", 32'(pos_x), SX);
    check("rst_pos_y", 32'(pos_y), 0);
    check("rst_active", 32'(active), 0);
    check("rst_q_valid", 32'(q_valid), 0);
    check("rst_game_over", 32'(game_over), 0);

    // Spawn miss, then right held 5 cycles with left/drop pulses dropped.
    spawn_ok();
    check("spawn_active", 32'(active), 1);
    check("spawn_x", 32'(pos_x), 4);
    right = 1; tick(); right = 0;
    for (int i = 0; i < 5; i++) begin
      check("wait_q_valid", 32'(q_valid), 1);
      check("wait_q_x", 32'(q_x), 5);
      if (i == 1) left = 1;
      if (i == 2) drop = 1;
      if (i == 4) begin q_resp_valid = 1; q_hit = 0; end
      tick();
      clear_in();
    end
    check("right_commit_x", 32'(pos_x), 5);
    check("right_commit_y", 32'(pos_y), 0);

    // Pure gravity with immediate misses: steps at FALL+9 and FALL+18.
    do_reset();
    spawn_ok();
    repeat (8) tick();
    check("grav1_q_valid", 32'(q_valid), 1);
    check("grav1_q_y", 32'(q_y), 1);
    q_resp_valid = 1; tick(); q_resp_valid = 0;
    check("grav1_pos_y", 32'(pos_y), 1);
    repeat (8) tick();
    check("grav2_q_valid", 32'(q_valid), 1);
    q_resp_valid = 1; tick(); q_resp_valid = 0;
    check("grav2_pos_y", 32'(pos_y), 2);

    // Gravity expiring during WAIT is serviced right after the commit.
    do_reset();
    spawn_ok();
    repeat (6) tick();
    right = 1; tick(); right = 0;
    tick(); tick();
    q_resp_valid = 1; tick(); q_resp_valid = 0;
    check("pend_x", 32'(pos_x), 5);
    tick();
    check("pend_q_valid", 32'(q_valid), 1);
    check("pend_q_y", 32'(q_y), 1);

    // Rotate beats left; left+right cancel.
    do_reset();
    spawn_ok();
    rotate = 1; left = 1; tick(); rotate = 0; left = 0;
    check("rotl_q_rot", 32'(q_rot), 1);
    check("rotl_q_x", 32'(q_x), 4);
    q_resp_valid = 1; tick(); q_resp_valid = 0;
    check("rotl_rot", 32'(rot), 1);
    left = 1; right = 1; tick(); left = 0; right = 0;
    check("lr_cancel_noq", 32'(q_valid), 0);
    check("lr_cancel_x", 32'(pos_x), 4);

    // Wall rejections.
    wall_test(1'b1, 4, 0);
    wall_test(1'b0, 5, 9);

    // Land at the floor without a query.
    do_reset();
    spawn_ok();
    drop_n(19);
    check("floor_y", 32'(pos_y), 19);
    drop = 1; tick(); drop = 0;
    check("floor_lock", 32'(lock_pulse), 1);
    check("floor_noq", 32'(q_valid), 0);
    check("floor_active", 32'(active), 0);
    tick();
    check("floor_lock_end", 32'(lock_pulse), 0);
    check("floor_keep_y", 32'(pos_y), 19);

    // Down move at y=10 colliding.
    do_reset();
    spawn_ok();
    drop_n(10);
    drop = 1; tick(); drop = 0;
    q_resp_valid = 1; q_hit = 1; tick(); clear_in();
    check("hit_lock", 32'(lock_pulse), 1);
    check("hit_active", 32'(active), 0);
    check("hit_y", 32'(pos_y), 10);
    tick();
    check("hit_lock_end", 32'(lock_pulse), 0);

    // Spawn collision: game over, everything after ignored.
    do_reset();
    spawn = 1; tick(); spawn = 0;
    q_resp_valid = 1; q_hit = 1; tick(); clear_in();
    check("over_flag", 32'(game_over), 1);
    check("over_active", 32'(active), 0);
    spawn = 1; rotate = 1; left = 1; drop = 1; tick(); tick(); clear_in();
    check("over_sticky", 32'(game_over), 1);
    check("over_noq", 32'(q_valid), 0);

    // Reset while a query is outstanding; a late response is ignored.
    do_reset();
    spawn_ok();
    rotate = 1; tick(); rotate = 0;
    check("rw_q_valid", 32'(q_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_rst_q_valid", 32'(q_valid), 0);
    check("rw_rst_active", 32'(active), 0);
    check("rw_rst_rot", 32'(rot), 0);
    q_resp_valid = 1; q_hit = 0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    q_resp_valid = 0;
    check("rw_late_q_valid", 32'(q_valid), 0);
    check("rw_late_active", 32'(active), 0);
    check("rw_late_x", 32'(pos_x), SX);

    // Randomized episodes against the model.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      in_q = 0;
      dly  = 0;
      for (int c = 0; c < 1500; c++) begin
        tick();
        if ($urandom_range(0, 599) == 0) begin
          clear_in();
          #2 rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
          in_q = 0;
          continue;
        end
        spawn  = ($urandom_range(0, 3) == 0);
        left   = ($urandom_range(0, 5) == 0);
        right  = ($urandom_range(0, 5) == 0);
        drop   = ($urandom_range(0, 3) == 0);
        rotate = ($urandom_range(0, 7) == 0);
        if (m_qv) begin
          if (!in_q) begin
            in_q = 1;
            dly  = $urandom_range(0, 4);
          end
          if (dly == 0) begin
            q_resp_valid = 1;
            q_hit = (m_ph == PH_SPAWNQ) ? ($urandom_range(0, 39) == 0)
                                        : ($urandom_range(0, 5) == 0);
            in_q = 0;
          end else begin
            dly--;
            q_resp_valid = 0;
            q_hit = $urandom_range(0, 1);
          end
        end else begin
          in_q = 0;
          q_resp_valid = ($urandom_range(0, 15) == 0);
          q_hit = $urandom_range(0, 1);
        end
      end
    end

    clear_in();
    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
